// File: rtl/keypad_uart_tx.sv
// Switch-keypad to UART sender: debounced send/EOL buttons, decimal or hex
// character map, hold-to-repeat, a small character FIFO and an 8N1 serializer.
module keypad_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DEB_CYCLES   = 500000,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       hex_mode,
  input  logic       btn,
  input  logic       btn_eol,
  output logic       out,
  output logic       pulse,
  output logic       busy,
  output logic       fifo_full,
  output logic       dropped
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int BIT_W   = $clog2(CLKS_PER_BIT);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE_V  = RPT_W'(REPEAT_RATE);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

  // Index 0 is the send button, index 1 the line-end button.
  logic [1:0]       raw, sync1, sync2, deb, deb_q, press;
  logic [DEB_W-1:0] deb_cnt [2];

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_fire;
  logic             pending_char, pending_cr, pending_lf;
  logic             svc_char, svc_cr, svc_lf;
  logic             char_ok, push_req, fifo_wr, fifo_pop;
  logic [7:0]       char_code, push_data;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             empty, full;

  ser_state_t       state, state_next;
  logic [BIT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign raw   = {btn_eol, btn};
  assign press = deb & ~deb_q;

  // A button state is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    char_ok   = 1'b1;
    char_code = 8'h30 + {4'h0, sw};
    if (sw > 4'd9) begin
      if (hex_mode) begin
        char_code = 8'h37 + {4'h0, sw};
      end else if (sw == 4'hF) begin
        char_code = 8'h55;
      end else begin
        char_ok   = 1'b0;
        char_code = 8'h00;
      end
    end
  end

  // One FIFO write per cycle: char beats CR beats LF; a full FIFO still consumes the flag.
  always_comb begin
    svc_char  = pending_char;
    svc_cr    = !pending_char && pending_cr;
    svc_lf    = !pending_char && !pending_cr && pending_lf;
    push_req  = 1'b0;
    push_data = 8'h00;
    if (svc_char) begin
      push_req  = char_ok;
      push_data = char_code;
    end else if (svc_cr) begin
      push_req  = 1'b1;
      push_data = 8'h0D;
    end else if (svc_lf) begin
      push_req  = 1'b1;
      push_data = 8'h0A;
    end
    fifo_wr = push_req && (!full || fifo_pop);
  end

  assign rpt_fire = deb[0] && !press[0] && (rpt_cnt == RPT_W'(1));

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      rpt_cnt      <= '0;
      pending_char <= 1'b0;
      pending_cr   <= 1'b0;
      pending_lf   <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      if (press[0])                  rpt_cnt <= RPT_DELAY_V;
      else if (!deb[0])              rpt_cnt <= '0;
      else if (rpt_cnt == RPT_W'(1)) rpt_cnt <= RPT_RATE_V;
      else if (rpt_cnt != '0)        rpt_cnt <= rpt_cnt - RPT_W'(1);
      pending_char <= press[0] | rpt_fire | (pending_char & ~svc_char);
      pending_cr   <= press[1] | (pending_cr & ~svc_cr);
      pending_lf   <= press[1] | (pending_lf & ~svc_lf);
      dropped      <= push_req && full && !fifo_pop;
    end
  end

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fifo_full = full;

  always_ff @(posedge sysclk) begin
    if (fifo_wr) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (fifo_wr)  wptr <= wptr + (AW+1)'(1);
      if (fifo_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  assign bit_end = (clk_cnt == BIT_LAST);

  always_ff @(posedge sysclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // STOP chains straight into START when more data waits, keeping frames contiguous.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          fifo_pop   = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            fifo_pop   = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (fifo_pop) shreg <= mem[rptr[AW-1:0]];
      if (state == IDLE || bit_end) clk_cnt <= '0;
      else                          clk_cnt <= clk_cnt + BIT_W'(1);
      if (state != DATA)            bit_idx <= '0;
      else if (bit_end)             bit_idx <= bit_idx + 3'd1;
    end
  end

  always_comb begin
    busy  = (state != IDLE);
    pulse = (state != IDLE) && (clk_cnt == '0);
    case (state)
      START:   out = 1'b0;
      DATA:    out = shreg[bit_idx];
      default: out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_keypad_uart_tx.sv
// Randomized bench for keypad_uart_tx: records the line every cycle, decodes
// UART frames from the trace and compares them with a spec-level model.
module tb_keypad_uart_tx;

  localparam int CPB   = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int RD    = 60;
  localparam int RR    = 40;
  localparam int MAXC  = 8192;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       hex_mode = 1'b0;
  logic       btn = 1'b0;
  logic       btn_eol = 1'b0;
  logic       out, pulse, busy, fifo_full, dropped;

  keypad_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEB_CYCLES  (DEB),
    .FIFO_DEPTH  (DEPTH),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .sw       (sw),
    .hex_mode (hex_mode),
    .btn      (btn),
    .btn_eol  (btn_eol),
    .out      (out),
    .pulse    (pulse),
    .busy     (busy),
    .fifo_full(fifo_full),
    .dropped  (dropped)
  );

  always #5 sysclk = ~sysclk;

  int   cyc = 0;
  logic out_h   [MAXC];
  logic pulse_h [MAXC];
  logic busy_h  [MAXC];
  logic full_h  [MAXC];
  logic drop_h  [MAXC];

  // Sample mid-cycle, away from the rising edge.
  always @(negedge sysclk) begin
    if (cyc < MAXC) begin
      out_h[cyc]   <= out;
      pulse_h[cyc] <= pulse;
      busy_h[cyc]  <= busy;
      full_h[cyc]  <= fifo_full;
      drop_h[cyc]  <= dropped;
    end
    cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic hx, input logic b,
                               input logic e, input int hold, input int low);
    sw       = s;
    hex_mode = hx;
    btn      = b;
    btn_eol  = e;
    tick(hold);
    btn     = 1'b0;
    btn_eol = 1'b0;
    tick(low);
  endtask

  // Character expected from the switch value: {valid, ascii}.
  function automatic logic [8:0] ref_char(input int v, input logic hx);
    if (v < 10) return {1'b1, 8'(48 + v)};
    if (hx)     return {1'b1, 8'(65 + v - 10)};
    if (v == 15) return {1'b1, 8'h55};
    return 9'h000;
  endfunction

  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         rx_bad;

  task automatic decode(input int a, input int b);
    int i;
    rx_q.delete();
    rx_t.delete();
    rx_bad = 0;
    i = a;
    while (i + 10 * CPB <= b) begin
      if (out_h[i] === 1'b0) begin
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = out_h[i + (j + 1) * CPB + CPB / 2];
        if (out_h[i + 9 * CPB + CPB / 2] !== 1'b1) rx_bad++;
        rx_q.push_back(v);
        rx_t.push_back(i);
        i += 10 * CPB;
      end else begin
        i++;
      end
    end
  endtask

  function automatic int count_hist(input int sel, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) begin
      if      (sel == 0 && pulse_h[i] === 1'b1) n++;
      else if (sel == 1 && busy_h[i]  === 1'b1) n++;
      else if (sel == 2 && full_h[i]  === 1'b1) n++;
      else if (sel == 3 && drop_h[i]  === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         r, s, a, hold, seen;
    logic [3:0] v;
    logic       hx;
    logic [8:0] ec;
    logic [9:0] frame;
    logic [3:0] gp, go;
    logic [7:0] exp_q [$];
    int         exp_t [$];

    // Reset state
    rst_n = 1'b0;
    tick(5);
    checkOutput("rst_out", 32'(out), 32'd1);
    checkOutput("rst_pulse", 32'(pulse), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_full", 32'(fifo_full), 32'd0);
    checkOutput("rst_dropped", 32'(dropped), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Decimal send of '7' with bit-level waveform check
    r = cyc;
    applyStimulus(4'd7, 1'b0, 1'b1, 1'b0, 20, 60);
    decode(r, cyc);
    ec = ref_char(7, 1'b0);
    checkOutput("dec_frames", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      checkOutput("dec_byte", 32'(rx_q[0]), 32'(ec[7:0]));
      checkOutput("dec_latency", 32'(rx_t[0] - r), 32'(DEB + 5));
      s = rx_t[0];
      frame = {1'b1, ec[7:0], 1'b0};
      for (int k = 0; k < 10; k++) begin
        for (int m = 0; m < 4; m++) begin
          gp[m] = pulse_h[s + k * CPB + m];
          go[m] = out_h[s + k * CPB + m];
        end
        checkOutput($sformatf("dec_bit%0d", k), 32'({gp, go}), 32'({4'b0001, {4{frame[k]}}}));
      end
    end
    checkOutput("dec_pulses", 32'(count_hist(0, r, cyc)), 32'd10);
    checkOutput("dec_busy", 32'(count_hist(1, r, cyc)), 32'(10 * CPB));

    // Map coverage: fixed corner cases then random switch/mode pairs
    for (int k = 0; k < 9; k++) begin
      if (k == 0)      begin v = 4'd12; hx = 1'b0; end
      else if (k == 1) begin v = 4'd12; hx = 1'b1; end
      else if (k == 2) begin v = 4'd15; hx = 1'b0; end
      else begin
        v  = 4'($urandom_range(0, 15));
        hx = 1'($urandom_range(0, 1));
      end
      ec   = ref_char(int'(v), hx);
      hold = $urandom_range(10, 30);
      r    = cyc;
      applyStimulus(v, hx, 1'b1, 1'b0, hold, 60);
      decode(r, cyc);
      checkOutput($sformatf("map%0d_frames", k), 32'(rx_q.size()), 32'(ec[8]));
      if (ec[8] && rx_q.size() == 1)
        checkOutput($sformatf("map%0d_byte", k), 32'(rx_q[0]), 32'(ec[7:0]));
      checkOutput($sformatf("map%0d_dropped", k), 32'(count_hist(3, r, cyc)), 32'd0);
    end

    // Bounce rejection
    v  = 4'($urandom_range(0, 9));
    sw = v;
    hex_mode = 1'b0;
    r  = cyc;
    for (int k = 0; k < 5; k++) begin
      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(2);
    end
    applyStimulus(v, 1'b0, 1'b1, 1'b0, 20, 60);
    decode(r, cyc);
    ec = ref_char(int'(v), 1'b0);
    checkOutput("bounce_frames", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) checkOutput("bounce_byte", 32'(rx_q[0]), 32'(ec[7:0]));

    // Line end: CR then LF, contiguous
    r = cyc;
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 10, 110);
    decode(r, cyc);
    checkOutput("eol_frames", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      checkOutput("eol_cr", 32'(rx_q[0]), 32'h0D);
      checkOutput("eol_lf", 32'(rx_q[1]), 32'h0A);
      checkOutput("eol_latency", 32'(rx_t[0] - r), 32'(DEB + 5));
      checkOutput("eol_gap", 32'(rx_t[1] - rx_t[0]), 32'(10 * CPB));
    end
    checkOutput("eol_busy", 32'(count_hist(1, r, cyc)), 32'(20 * CPB));
    checkOutput("eol_stopbits", 32'(rx_bad), 32'd0);

    // Overflow: 7 characters generated during the first frame
    exp_q.delete();
    r = cyc;
    for (int g = 0; g < 3; g++) begin
      v  = 4'($urandom_range(0, 9));
      ec = ref_char(int'(v), 1'b0);
      exp_q.push_back(ec[7:0]);
      if (g < 2) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
      applyStimulus(v, 1'b0, 1'b1, (g < 2), $urandom_range(5, 6), $urandom_range(5, 6));
    end
    tick(250);
    while (exp_q.size() > 1 + DEPTH) void'(exp_q.pop_back());
    decode(r, cyc);
    checkOutput("ovf_frames", 32'(rx_q.size()), 32'(1 + DEPTH));
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      checkOutput($sformatf("ovf_byte%0d", k), 32'(rx_q[k]), 32'(exp_q[k]));
    checkOutput("ovf_dropped", 32'(count_hist(3, r, cyc)), 32'd2);
    checkOutput("ovf_full_seen", 32'(count_hist(2, r, cyc) > 0), 32'd1);
    checkOutput("ovf_stopbits", 32'(rx_bad), 32'd0);

    // Auto-repeat: press, +REPEAT_DELAY, then every REPEAT_RATE while held
    v    = 4'($urandom_range(0, 15));
    ec   = ref_char(int'(v), 1'b1);
    hold = $urandom_range(185, 215);
    exp_t.delete();
    exp_t.push_back(0);
    for (int off = RD; off <= hold - 1; off += RR) exp_t.push_back(off);
    r = cyc;
    applyStimulus(v, 1'b1, 1'b1, 1'b0, hold, 150);
    decode(r, cyc);
    checkOutput("rpt_frames", 32'(rx_q.size()), 32'(exp_t.size()));
    if (rx_q.size() > 0) checkOutput("rpt_latency", 32'(rx_t[0] - r), 32'(DEB + 5));
    for (int k = 0; k < rx_q.size() && k < exp_t.size(); k++) begin
      checkOutput($sformatf("rpt_byte%0d", k), 32'(rx_q[k]), 32'(ec[7:0]));
      checkOutput($sformatf("rpt_time%0d", k), 32'(rx_t[k] - rx_t[0]), 32'(exp_t[k]));
    end

    // Reset during DATA bit 3 of CR, with LF still queued
    btn_eol = 1'b1;
    tick(8);
    btn_eol = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (out === 1'b0) begin
        seen = 1;
        break;
      end
      tick(1);
    end
    checkOutput("mid_start_seen", 32'(seen), 32'd1);
    tick(1 + 4 * CPB);
    rst_n = 1'b0;
    tick(1);
    checkOutput("mid_out", 32'(out), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_full", 32'(fifo_full), 32'd0);
    checkOutput("mid_pulse", 32'(pulse), 32'd0);
    rst_n = 1'b1;
    a = cyc;
    tick(150);
    decode(a, cyc);
    checkOutput("mid_no_frames", 32'(rx_q.size()), 32'd0);
    checkOutput("mid_no_busy", 32'(count_hist(1, a, cyc)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_uart_tx.md
# keypad_uart_tx

Parametrised switch-keypad-to-UART sender: a 4-bit switch value plus a "send" button becomes an ASCII character on a serial line. It supports decimal or hex mapping, a CR/LF line-end button, hold-to-repeat auto-repeat, and a FIFO that buffers keystrokes while the serializer is busy. It contains its own debouncers and 8N1 transmitter, and replaces the single-shot switch sender at the top of the board design, driving the UART pin directly.

## Interface
- CLKS_PER_BIT, 5208, sysclk cycles per UART bit (≥2)
- DEB_CYCLES, 500000, consecutive stable cycles before a button state is accepted (≥1)
- FIFO_DEPTH, 8, character buffer entries (power of 2, ≥2)
- REPEAT_DELAY, 25000000, cycles a debounced press must be held before the first repeat
- REPEAT_RATE, 5000000, cycles between subsequent repeats
- sysclk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sw  in  4  character select; bit 0 is LSB
- hex_mode  in  1  0 = decimal map, 1 = hex map
- btn  in  1  raw "send character" button
- btn_eol  in  1  raw "send CR LF" button
- out  out  1  UART TX, 8N1, LSB first, idle high
- pulse  out  1  1-cycle strobe at the first cycle of every transmitted bit period
- busy  out  1  serializer not IDLE
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- dropped  out  1  1-cycle strobe when a character is discarded because the FIFO is full

## Operation
- Reset (rst_n=0 at a sysclk edge) clears everything to the following state:
  - out=1, pulse=0, busy=0, fifo_full=0, dropped=0.
  - FIFO empty; both debounced states 0; repeat counter and pending flags cleared.
  - Serializer goes to IDLE. Reset mid-frame aborts the frame immediately.
- Debounce, per button:
  - 2-FF synchronizer, then a counter that is cleared whenever the synced value equals the debounced state.
  - When the counter reaches DEB_CYCLES, the debounced state toggles and the counter clears.
  - A press event is the debounced rising edge.
- Character map. sw and hex_mode are sampled in the cycle the push happens.
  - Decimal mode: 0–9 → 0x30–0x39; 15 → 0x55 ('U'); 10–14 invalid.
  - Hex mode: 0–9 → 0x30–0x39; 10–15 → 0x41–0x46.
  - An invalid value generates no push and does not assert dropped.
- Auto-repeat (btn only):
  - A press event sets pending_char and loads the repeat counter with REPEAT_DELAY.
  - While debounced btn stays high, the counter decrements each cycle. On expiry it sets pending_char and reloads REPEAT_RATE.
  - Debounced release clears the counter.
  - btn_eol never repeats.
- Push arbiter:
  - A btn_eol press event sets pending_cr and pending_lf.
  - At most one FIFO write per cycle, in priority order char, CR (0x0D), LF (0x0A).
  - Each pending flag clears when it is serviced.
  - If the FIFO is full at service time, the byte is discarded, dropped=1 for that cycle, and the flag still clears.
  - A new event for a flag that is already set is merged (no double push).
- FIFO: synchronous, with a write pointer and a read pointer of log2(FIFO_DEPTH)+1 bits each.
  - Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - A simultaneous write and pop on a full FIFO is allowed: the pop frees the slot in the same cycle.
- Serializer states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop into the shift register and go to START.
  - START: out=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit index counts them.
  - STOP: out=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - pulse=1 on the first cycle of each START, DATA-bit and STOP period.

## Timing
- Button to press event: DEB_CYCLES+2 cycles after the raw edge, counting the synchronizer and assuming the input stays stable.
- Press event to FIFO write: next cycle if no higher-priority flag is pending.
- FIFO write into an empty FIFO with the serializer in IDLE: pop on the following cycle; START (out=0, pulse=1) on the cycle after the pop.
- Frame length: 10×CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- CR/LF: written on consecutive cycles.
- Simultaneous char and eol press events: writes char, CR, LF on three consecutive cycles.

## Test plan
- Common parameters: CLKS_PER_BIT=4, DEB_CYCLES=3, FIFO_DEPTH=4, REPEAT_DELAY=60, REPEAT_RATE=40.
- Decimal send: sw=4'b0111, hex_mode=0, btn held 20 cycles → one frame of byte 0x37.
  - Serial bits: 0,1,1,1,0,1,1,0,0,1, each 4 cycles.
  - pulse fires 10 times; busy is high for 40 cycles.
- Map coverage: sw=12 with hex_mode=0 → no frame, dropped stays 0. sw=12 with hex_mode=1 → 0x43. sw=15 with hex_mode=0 → 0x55.
- Bounce rejection: btn toggles every 2 cycles for 20 cycles, then stays high → exactly one character sent.
- EOL plus overflow:
  - Press btn_eol → frames 0x0D then 0x0A back-to-back, 80 cycles total with no idle gap.
  - Separately, generate 7 characters while the serializer is busy → fifo_full asserts, dropped pulses once for each character lost, and the transmitted count equals 1 plus FIFO_DEPTH.
- Auto-repeat: btn held 200 cycles → first character at press, then repeats at +60, then every +40 until release; no further pushes after release.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 → the next cycle shows out=1, busy=0, FIFO empty, and no further frames.
